// File: rtl/csr_timer_unit.sv
// Multi-channel TID/TCFG/TVAL/TICLR timer CSR block with optional 64-bit stable counter.
// Optional feature macro: TIMER_STABLE_CNT_EN (free-running stable_cnt; tied to 0 when undefined).
module csr_timer_unit #(
  parameter int          NUM_TIMERS = 1,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] COREID     = 32'h0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [13:0]           csr_num,
  input  logic                  csr_we,
  input  logic [31:0]           csr_wmask,
  input  logic [31:0]           csr_wvalue,
  output logic [31:0]           csr_rvalue,
  output logic                  csr_hit,
  output logic [NUM_TIMERS-1:0] timer_int,
  output logic                  timer_int_any,
  output logic [63:0]           stable_cnt
);

  // CSR access is single-cycle: reads are combinational from current state,
  // writes commit on the next rising edge, so a same-cycle read sees the old value.
  logic       in_range, ch_ok;
  logic [1:0] sel_ch;
  logic [2:0] sel_off;
  logic       hit_tid, hit_tcfg, hit_tval, hit_ticlr;

  assign in_range  = (csr_num[13:5] == 9'd2);
  assign sel_ch    = csr_num[4:3];
  assign sel_off   = csr_num[2:0];
  assign ch_ok     = in_range && (int'(sel_ch) < NUM_TIMERS);
  assign hit_tid   = (csr_num == 14'h40);
  assign hit_tcfg  = ch_ok && (sel_off == 3'd1);
  assign hit_tval  = ch_ok && (sel_off == 3'd2);
  assign hit_ticlr = ch_ok && (sel_off == 3'd4);
  assign csr_hit   = hit_tid | hit_tcfg | hit_tval | hit_ticlr;

  logic [31:0] tid_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tid_q <= COREID;
    end else if (csr_we && hit_tid) begin
      tid_q <= (csr_wmask & csr_wvalue) | (~csr_wmask & tid_q);
    end
  end

  logic [31:0] cfg_rd [NUM_TIMERS];
  logic [31:0] cnt_rd [NUM_TIMERS];

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
    logic [CNT_W-1:0] cfg_q, cnt_q, cfg_wr;
    logic             pend_q, cfg_we, clr_we, fire;

    assign cfg_we = csr_we && hit_tcfg && (sel_ch == 2'(i));
    assign clr_we = csr_we && hit_ticlr && (sel_ch == 2'(i)) && csr_wmask[0] && csr_wvalue[0];
    assign cfg_wr = (csr_wmask[CNT_W-1:0] & csr_wvalue[CNT_W-1:0]) |
                    (~csr_wmask[CNT_W-1:0] & cfg_q);
    assign fire   = cfg_q[0] && (cnt_q == '0);

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        cfg_q  <= '0;
        cnt_q  <= '1;
        pend_q <= 1'b0;
      end else begin
        if (cfg_we) cfg_q <= cfg_wr;
        // An enabling TCFG write restarts the count and beats reload/decrement.
        if (cfg_we && cfg_wr[0]) begin
          cnt_q <= {cfg_wr[CNT_W-1:2], 2'b00};
        end else if (cfg_q[0] && (cnt_q != '1)) begin
          if ((cnt_q == '0) && cfg_q[1]) cnt_q <= {cfg_q[CNT_W-1:2], 2'b00};
          else                           cnt_q <= cnt_q - CNT_W'(1);
        end
        if (fire)        pend_q <= 1'b1;
        else if (clr_we) pend_q <= 1'b0;
      end
    end

    assign timer_int[i] = pend_q;
    assign cfg_rd[i]    = 32'(cfg_q);
    assign cnt_rd[i]    = 32'(cnt_q);
  end

  assign timer_int_any = |timer_int;

  always_comb begin
    csr_rvalue = '0;
    if (hit_tid) csr_rvalue = tid_q;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (sel_ch == 2'(i)) begin
        if (hit_tcfg) csr_rvalue = cfg_rd[i];
        if (hit_tval) csr_rvalue = cnt_rd[i];
      end
    end
  end

`ifdef TIMER_STABLE_CNT_EN
  logic [63:0] stable_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) stable_q <= '0;
    else         stable_q <= stable_q + 64'd1;
  end

  assign stable_cnt = stable_q;
`else
  assign stable_cnt = 64'h0;
`endif

endmodule

// File: tb/tb_csr_timer_unit.sv
// Randomised scoreboard bench for csr_timer_unit (2 channels, 16-bit counters)
// against a behavioural model of the timer CSR rules.
module tb_csr_timer_unit;

  localparam int          NT   = 2;
  localparam int          CW   = 16;
  localparam logic [31:0] CORE = 32'h0000_0003;
  localparam longint      CMAX = (longint'(1) << CW) - 1;
  localparam int          W    = 112 + NT;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [13:0]   csr_num = '0;
  logic          csr_we = 1'b0;
  logic [31:0]   csr_wmask = '0;
  logic [31:0]   csr_wvalue = '0;
  logic [31:0]   csr_rvalue;
  logic          csr_hit;
  logic [NT-1:0] timer_int;
  logic          timer_int_any;
  logic [63:0]   stable_cnt;

  csr_timer_unit #(.NUM_TIMERS(NT), .CNT_W(CW), .COREID(CORE)) dut (
    .clk(clk), .resetn(resetn), .csr_num(csr_num), .csr_we(csr_we),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue),
    .csr_hit(csr_hit), .timer_int(timer_int), .timer_int_any(timer_int_any),
    .stable_cnt(stable_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural model
  logic [31:0] m_tid;
  logic [31:0] m_cfg [NT];
  longint      m_cnt [NT];
  bit          m_pend [NT];
  logic [63:0] m_stable;

  logic [W-1:0] exp_q[$];
  logic         chk_vld = 1'b0;
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic model_reset();
    m_tid = CORE;
    for (int i = 0; i < NT; i++) begin
      m_cfg[i] = '0; m_cnt[i] = CMAX; m_pend[i] = 0;
    end
    m_stable = '0;
  endtask

  function automatic logic [W-1:0] expect_now(input logic [13:0] num);
    logic [31:0]   rv;
    logic          hit;
    logic [NT-1:0] pv;
    logic [63:0]   st;
    int            rel;
    rv = '0; hit = 1'b0;
    if (num == 14'h40) begin
      hit = 1'b1; rv = m_tid;
    end else if (int'(num) > 'h40 && int'(num) < 'h40 + 8 * NT) begin
      rel = int'(num) - 'h40;
      case (rel % 8)
        1: begin hit = 1'b1; rv = m_cfg[rel / 8]; end
        2: begin hit = 1'b1; rv = 32'(m_cnt[rel / 8]); end
        4: begin hit = 1'b1; rv = '0; end
        default: ;
      endcase
    end
    for (int i = 0; i < NT; i++) pv[i] = m_pend[i];
`ifdef TIMER_STABLE_CNT_EN
    st = m_stable;
`else
    st = 64'h0;
`endif
    return {num, rv, hit, pv, |pv, st};
  endfunction

  task automatic model_edge(input logic [13:0] num, input logic we,
                            input logic [31:0] mask, input logic [31:0] val);
    logic [31:0] ncfg;
    bit          tw, clr, np;
    longint      nc;
    for (int i = 0; i < NT; i++) begin
      tw   = we && (int'(num) == 'h41 + 8 * i);
      clr  = we && (int'(num) == 'h44 + 8 * i) && mask[0] && val[0];
      ncfg = tw ? (((mask & val) | (~mask & m_cfg[i])) & 32'(CMAX)) : m_cfg[i];
      np   = (m_cfg[i][0] && m_cnt[i] == 0) ? 1 : (clr ? 0 : m_pend[i]);
      if (tw && ncfg[0])                          nc = longint'(ncfg >> 2) * 4;
      else if (m_cfg[i][0] && m_cnt[i] != CMAX) begin
        if (m_cnt[i] == 0 && m_cfg[i][1])         nc = longint'(m_cfg[i] >> 2) * 4;
        else if (m_cnt[i] == 0)                   nc = CMAX;
        else                                      nc = m_cnt[i] - 1;
      end else                                    nc = m_cnt[i];
      m_cfg[i] = ncfg; m_cnt[i] = nc; m_pend[i] = np;
    end
    if (we && num == 14'h40) m_tid = (mask & val) | (~mask & m_tid);
    m_stable = m_stable + 64'd1;
  endtask

  // driver
  task automatic cycle(input logic [13:0] num, input logic we,
                       input logic [31:0] mask, input logic [31:0] val);
    csr_num = num; csr_we = we; csr_wmask = mask; csr_wvalue = val;
    exp_q.push_back(expect_now(num));
    chk_vld = 1'b1;
    @(posedge clk);
    model_edge(num, we, mask, val);
    #1;
    csr_we = 1'b0;
  endtask

  task automatic rd(input logic [13:0] num, input int n);
    for (int k = 0; k < n; k++) cycle(num, 1'b0, '0, '0);
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    cycle(num, 1'b1, mask, val);
  endtask

  // scoreboard monitor
  task automatic chk(input string name, input logic [13:0] num,
                     input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @csr %h: got %h expected %h", name, num, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [13:0]  a;
    if (chk_vld) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL queue_underflow: got empty expected entry");
      end else begin
        e = exp_q.pop_front();
        a = e[98+NT +: 14];
        chk("rvalue", a, 64'(csr_rvalue), 64'(e[66+NT +: 32]));
        chk("hit", a, 64'(csr_hit), 64'(e[65+NT]));
        chk("timer_int", a, 64'(timer_int), 64'(e[65 +: NT]));
        chk("timer_int_any", a, 64'(timer_int_any), 64'(e[64]));
        chk("stable_cnt", a, stable_cnt, e[63:0]);
      end
    end
  end

  logic [13:0] addr_tab [12] = '{14'h40, 14'h41, 14'h42, 14'h44, 14'h49, 14'h4A,
                                 14'h4C, 14'h48, 14'h51, 14'h43, 14'h00, 14'h61};

  initial begin
    logic [13:0] a;
    logic [31:0] m, v;
    model_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // reset state
    rd(14'h40, 1); rd(14'h41, 1); rd(14'h42, 1); rd(14'h4A, 1); rd(14'h44, 1);

    // one-shot INITVAL=5: 20 down to 0, pending, then halt at all-ones
    wr(14'h41, 32'hFFFF_FFFF, 32'h0000_0015);
    rd(14'h42, 26);

    // periodic INITVAL=2, clear away from zero then clear coinciding with zero
    wr(14'h41, 32'hFFFF_FFFF, 32'h0000_000B);
    rd(14'h42, 12);
    for (int k = 0; k < 20 && m_cnt[0] != 4; k++) rd(14'h42, 1);
    wr(14'h44, 32'h1, 32'h1);
    rd(14'h42, 2);
    for (int k = 0; k < 20 && m_cnt[0] != 0; k++) rd(14'h42, 1);
    wr(14'h44, 32'h1, 32'h1);
    rd(14'h42, 2);

    // channel 1 via 14'h49, bits above CNT_W ignored; out-of-range channel
    wr(14'h49, 32'hFFFF_FFFF, 32'h0001_0009);
    rd(14'h49, 1); rd(14'h4A, 10); rd(14'h51, 1); rd(14'h52, 1);
    wr(14'h41, 32'hFFFF_FFFF, 32'h0); rd(14'h42, 2);

    // masked write disables without touching PERIODIC/INITVAL
    wr(14'h41, 32'hFFFF_FFFF, 32'h0000_0007);
    rd(14'h42, 2);
    wr(14'h41, 32'h0000_0001, 32'h0);
    rd(14'h41, 1); rd(14'h42, 4);

    // TID masked write
    wr(14'h40, 32'h0000_FF00, 32'hABCD_5A5A); rd(14'h40, 1);

    // randomised traffic
    for (int k = 0; k < 500; k++) begin
      a = addr_tab[$urandom_range(0, 11)];
      m = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
      v = $urandom_range(0, 255) | (($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_0000) : 32'h0);
      cycle(a, ($urandom_range(0, 2) == 0), m, v);
    end

    // asynchronous reset mid-count
    wr(14'h41, 32'hFFFF_FFFF, 32'h0000_0013);
    rd(14'h42, 3);
    chk_vld = 1'b0;
    #1;
    resetn = 1'b0;
    model_reset();
    csr_num = 14'h42; csr_we = 1'b0;
    exp_q.push_back(expect_now(14'h42));
    chk_vld = 1'b1;
    @(negedge clk);
    #1 chk_vld = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    rd(14'h41, 1); rd(14'h42, 3);

    chk_vld = 1'b0;
    #20;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
